// File: rtl/line_burst_adapter_if.sv
// Line-wide request/response signals on the upstream side and the narrow
// beat bus on the memory side, shared between the adapter and its environment.
interface line_burst_adapter_if #(
    parameter int LINE_WIDTH = 128,
    parameter int BEAT_WIDTH = 32
);
    logic                  mem_read;
    logic                  mem_write;
    logic [15:0]           mem_address;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic                  mem_resp;
    logic [LINE_WIDTH-1:0] mem_rdata;

    logic                  bmem_read;
    logic                  bmem_write;
    logic [15:0]           bmem_address;
    logic [BEAT_WIDTH-1:0] bmem_wdata;
    logic [BEAT_WIDTH-1:0] bmem_rdata;
    logic                  bmem_resp;

    // Adapter view: serves line requests, drives the beat bus.
    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_resp, mem_rdata,
        output bmem_read, bmem_write, bmem_address, bmem_wdata,
        input  bmem_rdata, bmem_resp
    );

    // Environment view: issues line requests, plays the physical memory.
    modport master (
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_resp, mem_rdata,
        input  bmem_read, bmem_write, bmem_address, bmem_wdata,
        output bmem_rdata, bmem_resp
    );
endinterface

// File: rtl/line_burst_adapter.sv
// Splits each line read/write into a fixed burst of narrow beats and
// reassembles read beats into a line returned with a one-cycle mem_resp.
module line_burst_adapter #(
    parameter int LINE_WIDTH = 128,
    parameter int BEAT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    line_burst_adapter_if.slave  bus
);
    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        WRITE_BURST = 2'b01,
        READ_BURST  = 2'b10,
        DONE        = 2'b11
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_s;
    logic [11:0]           line_addr_r;
    logic [LINE_WIDTH-1:0] wbuf_r;
    logic [LINE_WIDTH-1:0] rbuf_r;
    logic [LINE_WIDTH-1:0] wbuf_shift_s;
    logic                  latch_wr_s;
    logic                  latch_rd_s;
    logic                  capture_s;
    logic                  mem_resp_r;
    logic                  bmem_read_r;
    logic                  bmem_write_r;

    // State and beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state, counter and buffer-enable decode; requests are only looked at in IDLE.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        latch_wr_s = 1'b0;
        latch_rd_s = 1'b0;
        capture_s  = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_s = {CNT_W{1'b0}};
                if (bus.mem_write) begin
                    state_s    = WRITE_BURST;
                    latch_wr_s = 1'b1;
                end else if (bus.mem_read) begin
                    state_s    = READ_BURST;
                    latch_rd_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE_BURST: begin
                if (bus.bmem_resp) begin
                    // The increment wraps LAST_BEAT -> 0 exactly as the burst ends.
                    cnt_s = cnt_r + CNT_ONE;
                    if (cnt_r == LAST_BEAT) begin
                        state_s = DONE;
                    end else begin
                        state_s = WRITE_BURST;
                    end
                end else begin
                    state_s = WRITE_BURST;
                end
            end
            READ_BURST: begin
                if (bus.bmem_resp) begin
                    capture_s = 1'b1;
                    cnt_s     = cnt_r + CNT_ONE;
                    if (cnt_r == LAST_BEAT) begin
                        state_s = DONE;
                    end else begin
                        state_s = READ_BURST;
                    end
                end else begin
                    state_s = READ_BURST;
                end
            end
            DONE: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Request capture: address for both directions, write line only for writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_addr_r <= 12'h000;
            wbuf_r      <= {LINE_WIDTH{1'b0}};
        end else if (latch_wr_s) begin
            line_addr_r <= bus.mem_address[15:4];
            wbuf_r      <= bus.mem_wdata;
        end else if (latch_rd_s) begin
            line_addr_r <= bus.mem_address[15:4];
        end else begin
            line_addr_r <= line_addr_r;
            wbuf_r      <= wbuf_r;
        end
    end

    // Read line assembly; a reset mid-burst discards any partial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbuf_r <= {LINE_WIDTH{1'b0}};
        end else if (capture_s) begin
            rbuf_r[int'(cnt_r) * BEAT_WIDTH +: BEAT_WIDTH] <= bus.bmem_rdata;
        end else begin
            rbuf_r <= rbuf_r;
        end
    end

    // Control outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_resp_r   <= 1'b0;
            bmem_read_r  <= 1'b0;
            bmem_write_r <= 1'b0;
        end else begin
            mem_resp_r   <= (state_s == DONE);
            bmem_read_r  <= (state_s == READ_BURST);
            bmem_write_r <= (state_s == WRITE_BURST);
        end
    end

    // Beat 0 is the least-significant slice of the line.
    always_comb begin
        wbuf_shift_s = wbuf_r >> (int'(cnt_r) * BEAT_WIDTH);
    end

    assign bus.mem_resp     = mem_resp_r;
    assign bus.mem_rdata    = rbuf_r;
    assign bus.bmem_read    = bmem_read_r;
    assign bus.bmem_write   = bmem_write_r;
    assign bus.bmem_address = (state_r == IDLE) ? 16'h0000 : {line_addr_r, 4'b0000};
    assign bus.bmem_wdata   = (state_r == WRITE_BURST) ? wbuf_shift_s[BEAT_WIDTH-1:0]
                                                       : {BEAT_WIDTH{1'b0}};
endmodule
